// File: rtl/div_16_8_seq.sv
// ---------------------------------------------------------------------------
// div_16_8_seq
//   Sequential unsigned 16/8 restoring divider. One quotient bit is produced
//   per clock, so a division takes 8 cycles from accept to result. Operands are
//   accepted with a valid/ready handshake, and the result is offered the same
//   way. The result is held until the consumer takes it and is kept after that.
//
// Ports
//   clk        in   1   clock, all state on rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operand pair offered
//   in_ready   out  1   high only while idle
//   dividend   in  16   unsigned dividend
//   divisor    in   8   unsigned divisor
//   out_valid  out  1   result available (DONE state)
//   out_ready  in   1   consumer takes result
//   quotient   out  8   unsigned quotient
//   remainder  out  8   unsigned remainder
//   ovf        out  1   quotient overflow / divide-by-zero flag
//
// Build option
//   DIV_OVF_DETECT_EN : when defined, operands with dividend[15:8] >= divisor
//   (this includes divisor == 0) skip the iteration. They complete one cycle
//   after accept with quotient = remainder = 0xFF and ovf = 1. When the macro
//   is undefined, ovf is tied to 0 and every division runs all 8 steps.
// ---------------------------------------------------------------------------
module div_16_8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [2:0]  r_cnt;
  // The partial remainder is held as 8 bits. The ninth bit of R is never
  // consumed, because each step shifts only R[7:0] into the trial value.
  logic [7:0]  r_rem;
  logic [7:0]  r_dvd_lo;    // remaining dividend bits, next one at [7]
  logic [7:0]  r_dvs;
  logic [7:0]  r_quo;
  logic [7:0]  r_quotient;
  logic [7:0]  r_remainder;

  logic        w_accept;
  logic        w_last;
  logic        w_qbit;
  logic [7:0]  w_rem_nxt;
  logic        w_ovf_pend;

  // One restoring step: T = {R[7:0], next dividend bit}, subtract if it fits.
  // Returns {quotient bit, new R[7:0]}.
  function automatic logic [8:0] div_step(input logic [7:0] rem_in,
                                          input logic       dvd_bit,
                                          input logic [7:0] dvs_in);
    logic [8:0] t;
    logic [8:0] d;
    t = {rem_in, dvd_bit};
    d = {1'b0, dvs_in};
    if (t >= d) begin
      t = t - d;
      return {1'b1, t[7:0]};
    end
    return {1'b0, t[7:0]};
  endfunction

  assign {w_qbit, w_rem_nxt} = div_step(r_rem, r_dvd_lo[7], r_dvs);

  assign w_accept  = in_valid && (r_state == IDLE);
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

`ifdef DIV_OVF_DETECT_EN
  logic r_ovf_pend;
  logic r_ovf;

  // Overflow is decided at accept. A pending overflow spends exactly one
  // BUSY cycle and then reports the saturated result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_accept) begin
      r_ovf_pend <= (dividend[15:8] >= divisor);
    end else if (r_state == BUSY) begin
      if (r_ovf_pend) begin
        r_ovf <= 1'b1;
      end else if (r_cnt == 3'd7) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign w_ovf_pend = r_ovf_pend;
  assign ovf        = r_ovf;
`else
  assign w_ovf_pend = 1'b0;
  assign ovf        = 1'b0;
`endif

  assign w_last = w_ovf_pend || (r_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = BUSY;
      BUSY:    if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 3'd0;
      r_rem       <= 8'd0;
      r_dvd_lo    <= 8'd0;
      r_dvs       <= 8'd0;
      r_quo       <= 8'd0;
      r_quotient  <= 8'd0;
      r_remainder <= 8'd0;
    end else if (w_accept) begin
      r_cnt    <= 3'd0;
      r_rem    <= dividend[15:8];
      r_dvd_lo <= dividend[7:0];
      r_dvs    <= divisor;
      r_quo    <= 8'd0;
    end else if (r_state == BUSY) begin
      if (w_ovf_pend) begin
        r_quotient  <= 8'hFF;
        r_remainder <= 8'hFF;
      end else begin
        r_cnt    <= r_cnt + 3'd1;
        r_rem    <= w_rem_nxt;
        r_dvd_lo <= {r_dvd_lo[6:0], 1'b0};
        r_quo    <= {r_quo[6:0], w_qbit};
        // The visible result changes only when the final step completes.
        // This keeps it stable in IDLE and while DONE waits for out_ready.
        if (r_cnt == 3'd7) begin
          r_quotient  <= {r_quo[6:0], w_qbit};
          r_remainder <= w_rem_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_16_8_seq.sv
module tb_div_16_8_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        ovf;

  int n_chk;
  int n_bad;

  div_16_8_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Offers one operand pair and measures the edges from accept to out_valid.
  // While the divider works, the bench keeps in_valid high with junk operands
  // to show that they are ignored. Then it holds out_ready low for hold_cyc
  // cycles before it takes the result.
  task automatic run_div(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                         input int exp_lat, input logic [7:0] eq, input logic [7:0] er,
                         input logic eo, input int hold_cyc);
    int n;
    check({tag, ".in_ready_pre"}, in_ready, 1'b1);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk);           // accepting edge
    #1;
    dividend = 16'hBEEF;
    divisor  = 8'h03;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    in_valid = 1'b0;
    check({tag, ".latency"}, n, exp_lat);
    check({tag, ".quotient"}, quotient, eq);
    check({tag, ".remainder"}, remainder, er);
    check({tag, ".ovf"}, ovf, eo);
    for (int k = 0; k < hold_cyc; k++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, out_valid, 1'b1);
      check({tag, ".hold_q"}, quotient, eq);
      check({tag, ".hold_r"}, remainder, er);
      check({tag, ".hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    check({tag, ".in_ready_hs"}, in_ready, 1'b0);
    @(posedge clk);           // handshake edge
    #1;
    out_ready = 1'b0;
    check({tag, ".valid_after"}, out_valid, 1'b0);
    check({tag, ".in_ready_after"}, in_ready, 1'b1);
    @(posedge clk);
    #1;
    check({tag, ".q_retained"}, quotient, eq);
    check({tag, ".r_retained"}, remainder, er);
  endtask

  initial begin
    n_chk     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 16'h0;
    divisor   = 8'h0;
    #13;
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.quotient", quotient, 8'h00);
    check("rst.remainder", remainder, 8'h00);
    check("rst.ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 4000 / 32 = 125 r 0
    run_div("d0FA0", 16'h0FA0, 8'h20, 8, 8'h7D, 8'h00, 1'b0, 0);
    // 65279 / 255 = 255 r 254
    run_div("dFEFF", 16'hFEFF, 8'hFF, 8, 8'hFF, 8'hFE, 1'b0, 0);
`ifdef DIV_OVF_DETECT_EN
    run_div("ovf1234", 16'h1234, 8'h12, 1, 8'hFF, 8'hFF, 1'b1, 0);
    // A normal division after an overflow clears the flag.
    run_div("d0064a", 16'h0064, 8'h07, 8, 8'h0E, 8'h02, 1'b0, 0);
`else
    run_div("dz00AB", 16'h00AB, 8'h00, 8, 8'hFF, 8'hAB, 1'b0, 0);
`endif
    // 255 / 16 = 15 r 15, consumer stalls for 5 cycles
    run_div("d00FF", 16'h00FF, 8'h10, 8, 8'h0F, 8'h0F, 1'b0, 5);

    // Reset in the middle of a division
    dividend = 16'h0FA0;
    divisor  = 8'h20;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort.out_valid", out_valid, 1'b0);
    check("abort.quotient", quotient, 8'h00);
    check("abort.remainder", remainder, 8'h00);
    check("abort.in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("abort.no_result", out_valid, 1'b0);
    end
    // 100 / 7 = 14 r 2
    run_div("d0064", 16'h0064, 8'h07, 8, 8'h0E, 8'h02, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
